xpb_csa_accum: RTL and testbench
================================

Name: xpb_csa_accum

Overview:
- Downstream consumer of the xpb lookup-table bank in the modular-squaring reduction path.
- Each LUT returns a 1024-bit precomputed multiple (xpb) for one 5-bit digit of the upper product bits. This block accepts those values as a stream, one per cycle.
- Accumulates the stream in carry-save form, then resolves to a single binary sum with a segmented carry-propagate adder.
- Emits the unreduced sum (DATA_W plus guard bits) to the final reduction stage.

Parameters:
- DATA_W, 1024: width of each incoming xpb term.
- SEG_W, 64: carry-propagate segment width resolved per cycle.
- GUARD_W, 64: extra high bits absorbing growth of the sum. ACC_W = DATA_W + GUARD_W must be a multiple of SEG_W.
- NSEG, ACC_W/SEG_W (derived, 17 by default): number of resolve cycles.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- in_data, input, DATA_W: xpb term from the LUT bank.
- in_valid, input, 1: term valid.
- in_last, input, 1: marks the final term of a packet. Qualified by in_valid.
- in_ready, output, 1: block can accept a term.
- out_data, output, ACC_W: resolved sum.
- out_valid, output, 1: sum valid.
- out_ready, input, 1: downstream accepts the sum.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- rst asserted forces state IDLE and clears sum_r, carry_r, the segment index, the resolve carry bit and out_data to 0. out_valid is 0. in_ready is 1 once state is IDLE.
- The same applies mid-ACCUM or mid-RESOLVE: the partial packet is discarded with no output.
- State machine: IDLE, ACCUM, RESOLVE, OUT. in_ready = (state==IDLE or state==ACCUM). A beat is accepted on in_valid & in_ready.
- IDLE, on accept: sum_r <= in_data zero-extended to ACC_W; carry_r <= 0. Next state is RESOLVE if in_last, otherwise ACCUM.
- ACCUM, on accept: 3:2 compress.
  - sum_r <= sum_r ^ carry_r ^ in_ext.
  - carry_r <= majority(sum_r, carry_r, in_ext) << 1, truncated to ACC_W.
  - If in_last, go to RESOLVE. With no accept, the state holds.
- RESOLVE, one segment per cycle, index i = 0..NSEG-1 from the LSB.
  - {c, seg_i} <= sum_r[i] + carry_r[i] + c, with c starting at 0. The result is written into sum_r segment i.
  - After segment NSEG-1, go to OUT. The final carry-out is dropped; GUARD_W guarantees it is 0.
- OUT: out_valid=1 and out_data=sum_r. Both hold stable until out_ready. On out_valid & out_ready, go to IDLE and out_valid drops on the next cycle. No new term is accepted until IDLE.
- Latency:
  - out_valid rises NSEG+1 clocks after the edge accepting the in_last beat (18 by default).
  - The earliest next accept is the cycle after the handshake.
- Single-term packet (in_last on first beat): the output equals that term.
- in_last or in_data while in_valid=0 are ignored.
- A packet longer than 2^GUARD_W terms is outside the supported range. Behaviour is unspecified unless the optional feature is enabled.

Optional Feature:
- Macro XPB_CSA_ACCUM_TERM_CNT_EN.
- When defined:
  - Adds a 16-bit saturating term counter, cleared at each IDLE accept, and output port term_cnt [15:0], registered and valid with out_valid.
  - Adds output ovf [0:0], which goes to 1 if the count exceeds 2^min(GUARD_W,15). ovf holds until the next IDLE accept or reset.
  - Both reset to 0.
- When undefined: neither port nor the counter exists, and the behaviour is otherwise identical.

Decomposition:
- Package xpb_pkg holds:
  - DATA_W/SEG_W/GUARD_W defaults and the derived ACC_W/NSEG functions.
  - The state enum type (IDLE, ACCUM, RESOLVE, OUT).
  - The counter width constant.
- One sub-module, xpb_seg_add: a combinational SEG_W adder with carry-in/carry-out, instantiated once and muxed by segment index.

Test Plan:
- Single term 5 with in_last, out_ready=1 -> out_data=5, out_valid exactly 18 cycles after the accept, one cycle wide.
- Two terms, each 2^1024-1 -> out_data = 2^1025-2 (bit 1024 set, bit 0 clear).
- Terms 2^64-1, then 1 -> out_data=2^64, checking carry across the segment-0/1 boundary. Also terms 2^1088-2^1024... must not occur; instead a chain of 3 terms of 2^1024-1 -> 3*2^1024-3.
- Hold out_ready=0 for 10 cycles in OUT -> out_data stable, in_ready=0, in_valid beats not accepted. Release -> IDLE, next beat accepted the following cycle.
- Assert rst at resolve segment 8 -> out_valid=0 and in_ready=1 immediately after reset. A new packet {7} yields 7 (no stale data).
- With XPB_CSA_ACCUM_TERM_CNT_EN and GUARD_W=4, send 17 terms of 1 -> term_cnt=17, ovf=1. With 16 terms -> term_cnt=16, ovf=0, out_data=16.

Source files
------------

// File: rtl/xpb_pkg.sv
// Shared defaults, derived-width helpers and FSM state type for the xpb
// carry-save accumulator.
package xpb_pkg;

    localparam int unsigned DATA_W_DEF  = 1024;
    localparam int unsigned SEG_W_DEF   = 64;
    localparam int unsigned GUARD_W_DEF = 64;
    localparam int unsigned CNT_W       = 16;

    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned guard_w);
        return data_w + guard_w;
    endfunction

    function automatic int unsigned nseg(input int unsigned acc, input int unsigned seg);
        return acc / seg;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUT     = 2'd3
    } state_t;

endpackage

// File: rtl/xpb_seg_add.sv
// Combinational SEG_W-bit adder with carry-in/carry-out, one resolve segment.
module xpb_seg_add #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);

endmodule

// File: rtl/xpb_csa_accum.sv
// Carry-save accumulator for xpb terms with segmented carry-propagate resolve.
// Optional term counter / overflow flag: define XPB_CSA_ACCUM_TERM_CNT_EN.
module xpb_csa_accum
    import xpb_pkg::*;
#(
    parameter  int unsigned DATA_W  = DATA_W_DEF,
    parameter  int unsigned SEG_W   = SEG_W_DEF,
    parameter  int unsigned GUARD_W = GUARD_W_DEF,
    localparam int unsigned ACC_W   = acc_w(DATA_W, GUARD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef XPB_CSA_ACCUM_TERM_CNT_EN
    ,
    output logic [CNT_W-1:0]  term_cnt,
    output logic [0:0]        ovf
`endif
);

    localparam int unsigned NSEG      = nseg(ACC_W, SEG_W);
    localparam int unsigned SEG_IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    if ((ACC_W % SEG_W) != 0) begin : g_bad_seg
        $error("ACC_W must be a multiple of SEG_W");
    end

    state_t               state;
    state_t               state_nxt;
    logic                 in_ready_nxt;
    logic                 out_valid_nxt;

    logic [ACC_W-1:0]     sum_r;
    logic [ACC_W-1:0]     carry_r;
    logic [ACC_W-1:0]     in_ext;
    logic [SEG_IDX_W-1:0] seg_idx;
    logic                 rc;

    logic                 accept;
    logic                 seg_last;
    logic [SEG_W-1:0]     seg_a;
    logic [SEG_W-1:0]     seg_b;
    logic [SEG_W-1:0]     seg_s;
    logic                 seg_co;

    assign in_ext   = ACC_W'(in_data);
    assign accept   = in_valid & in_ready;
    assign seg_last = (seg_idx == SEG_IDX_W'(NSEG - 1));
    assign seg_a    = sum_r[32'(seg_idx) * SEG_W +: SEG_W];
    assign seg_b    = carry_r[32'(seg_idx) * SEG_W +: SEG_W];
    assign out_data = sum_r;

    xpb_seg_add #(
        .W (SEG_W)
    ) u_seg_add (
        .a  (seg_a),
        .b  (seg_b),
        .ci (rc),
        .s  (seg_s),
        .co (seg_co)
    );

    // State and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? RESOLVE : ACCUM;
            ACCUM:   if (accept && in_last) state_nxt = RESOLVE;
            RESOLVE: if (seg_last) state_nxt = OUT;
            OUT:     if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out_valid rises one cycle after entering OUT and drops after the handshake
    always_comb begin
        in_ready_nxt  = (state_nxt == IDLE) || (state_nxt == ACCUM);
        out_valid_nxt = (state == OUT) && !(out_valid && out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r   <= '0;
            carry_r <= '0;
            seg_idx <= '0;
            rc      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sum_r   <= in_ext;
                        carry_r <= '0;
                        seg_idx <= '0;
                        rc      <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        sum_r   <= sum_r ^ carry_r ^ in_ext;
                        carry_r <= ((sum_r & carry_r) | (sum_r & in_ext) | (carry_r & in_ext)) << 1;
                    end
                end
                RESOLVE: begin
                    // Final carry-out is dropped; guard bits keep it zero
                    sum_r[32'(seg_idx) * SEG_W +: SEG_W] <= seg_s;
                    rc      <= seg_last ? 1'b0 : seg_co;
                    seg_idx <= seg_last ? '0 : seg_idx + SEG_IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef XPB_CSA_ACCUM_TERM_CNT_EN
    localparam int unsigned    OVF_EXP = (GUARD_W < 15) ? GUARD_W : 15;
    localparam logic [CNT_W-1:0] OVF_LIM = CNT_W'(1) << OVF_EXP;

    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (&term_cnt) ? term_cnt : term_cnt + CNT_W'(1);

    // Saturating term count; ovf is sticky until the next packet starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_cnt <= '0;
            ovf      <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                term_cnt <= CNT_W'(1);
                ovf      <= '0;
            end else begin
                term_cnt <= cnt_inc;
                ovf      <= ovf | (cnt_inc > OVF_LIM);
            end
        end
    end
`endif

endmodule

// File: tb/tb_xpb_csa_accum.sv
// Directed self-checking bench for xpb_csa_accum (table vectors plus
// hand-written hold, reset and counter sequences).
module tb_xpb_csa_accum;

    localparam int unsigned DATA_W  = 1024;
`ifdef XPB_CSA_ACCUM_TERM_CNT_EN
    localparam int unsigned GUARD_W = 4;
    localparam int unsigned SEG_W   = 4;
`else
    localparam int unsigned GUARD_W = 64;
    localparam int unsigned SEG_W   = 64;
`endif
    localparam int unsigned ACC_W   = DATA_W + GUARD_W;
    localparam int unsigned NSEG    = ACC_W / SEG_W;
    localparam int unsigned LAT     = NSEG + 1;
    localparam int          NVEC    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
`ifdef XPB_CSA_ACCUM_TERM_CNT_EN
    logic [15:0]       term_cnt;
    logic [0:0]        ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int                n;
        logic [DATA_W-1:0] t0;
        logic [DATA_W-1:0] t1;
        logic [DATA_W-1:0] t2;
        logic [ACC_W-1:0]  exp;
    } vec_t;

    vec_t vecs[NVEC];

    xpb_csa_accum #(
        .DATA_W  (DATA_W),
        .SEG_W   (SEG_W),
        .GUARD_W (GUARD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef XPB_CSA_ACCUM_TERM_CNT_EN
        ,
        .term_cnt  (term_cnt),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk_vec(input int n, input logic [DATA_W-1:0] t0, t1, t2,
                                    input logic [ACC_W-1:0] exp);
        vec_t v;
        v.n = n; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", name,
                     got[ACC_W-1 -: 64], got[63:0], want[ACC_W-1 -: 64], want[63:0]);
        end
    endtask

    // Sends n beats (term i = t0, t1, then t2 repeated), waits for out_valid
    // and checks latency and sum; with out_ready=1 also checks the pulse width.
    task automatic run_packet(input string name, input int n,
                              input logic [DATA_W-1:0] t0, t1, t2,
                              input logic [ACC_W-1:0] exp);
        int acc_cyc;
        int k;
        acc_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? t0 : (i == 1) ? t1 : t2;
            in_last  = (i == n - 1);
            k = 0;
            while (!in_ready && k < 50) begin
                @(posedge clk); #1; k++;
            end
            if (!in_ready) begin
                check({name, " accept timeout"}, ACC_W'(in_ready), ACC_W'(1'b1));
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            acc_cyc = cyc;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        k = 0;
        while (!out_valid && k < int'(LAT) + 20) begin
            @(posedge clk); #1; k++;
        end
        check({name, " out_valid seen"}, ACC_W'(out_valid), ACC_W'(1'b1));
        check({name, " latency"}, ACC_W'(cyc - acc_cyc), ACC_W'(LAT));
        check({name, " data"}, out_data, exp);
        if (out_ready) begin
            @(posedge clk); #1;
            check({name, " one-cycle valid"}, ACC_W'(out_valid), ACC_W'(1'b0));
            check({name, " ready after"}, ACC_W'(in_ready), ACC_W'(1'b1));
        end
    endtask

    initial begin
        logic [DATA_W-1:0] ones;
        ones = '1;

        vecs[0] = mk_vec(1, DATA_W'(5), '0, '0, ACC_W'(5));
        vecs[1] = mk_vec(2, ones, ones, '0, (ACC_W'(1) << (DATA_W + 1)) - ACC_W'(2));
        vecs[2] = mk_vec(2, DATA_W'(64'hFFFF_FFFF_FFFF_FFFF), DATA_W'(1), '0, ACC_W'(1) << 64);
        vecs[3] = mk_vec(3, ones, ones, ones, (ACC_W'(3) << DATA_W) - ACC_W'(3));
        vecs[4] = mk_vec(3, DATA_W'(1) << 1023, DATA_W'(1) << 1023, DATA_W'(1) << 1023,
                         ACC_W'(3) << 1023);

        rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", ACC_W'(in_ready), ACC_W'(1'b1));
        check("reset out_valid", ACC_W'(out_valid), ACC_W'(1'b0));
        check("reset out_data", out_data, '0);
`ifdef XPB_CSA_ACCUM_TERM_CNT_EN
        check("reset term_cnt", ACC_W'(term_cnt), '0);
        check("reset ovf", ACC_W'(ovf), '0);
`endif
        rst = 1'b0;

        // in_last/in_data without in_valid must be ignored
        in_last = 1'b1; in_data = DATA_W'(123);
        repeat (3) @(posedge clk);
        #1;
        check("idle ignores invalid", ACC_W'(in_ready), ACC_W'(1'b1));
        in_last = 1'b0;

        for (int v = 0; v < NVEC; v++)
            run_packet($sformatf("vec%0d", v), vecs[v].n, vecs[v].t0, vecs[v].t1, vecs[v].t2, vecs[v].exp);

        // Backpressure: OUT holds for 10 cycles, extra beats are refused
        out_ready = 1'b0;
        run_packet("hold", 2, DATA_W'(2), DATA_W'(3), '0, ACC_W'(5));
        in_valid = 1'b1; in_data = DATA_W'(99); in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold data c%0d", i), out_data, ACC_W'(5));
            check($sformatf("hold valid c%0d", i), ACC_W'(out_valid), ACC_W'(1'b1));
            check($sformatf("hold ready c%0d", i), ACC_W'(in_ready), ACC_W'(1'b0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release valid", ACC_W'(out_valid), ACC_W'(1'b0));
        check("release ready", ACC_W'(in_ready), ACC_W'(1'b1));
        in_valid = 1'b1; in_data = DATA_W'(9); in_last = 1'b1;
        @(posedge clk); #1;
        check("next accept immediate", ACC_W'(in_ready), ACC_W'(1'b0));
        in_valid = 1'b0; in_last = 1'b0;
        for (int k = 0; k < int'(LAT) + 20 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("post-release data", out_data, ACC_W'(9));
        @(posedge clk); #1;

        // Reset in the middle of resolve at segment 8
        in_valid = 1'b1; in_data = DATA_W'(4); in_last = 1'b0;
        @(posedge clk); #1;
        in_data = DATA_W'(6); in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset out_valid", ACC_W'(out_valid), ACC_W'(1'b0));
        check("midreset in_ready", ACC_W'(in_ready), ACC_W'(1'b1));
        check("midreset out_data", out_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_packet("after reset", 1, DATA_W'(7), '0, '0, ACC_W'(7));

`ifdef XPB_CSA_ACCUM_TERM_CNT_EN
        run_packet("cnt17", 17, DATA_W'(1), DATA_W'(1), DATA_W'(1), ACC_W'(17));
        check("cnt17 term_cnt", ACC_W'(term_cnt), ACC_W'(17));
        check("cnt17 ovf", ACC_W'(ovf), ACC_W'(1'b1));
        run_packet("cnt16", 16, DATA_W'(1), DATA_W'(1), DATA_W'(1), ACC_W'(16));
        check("cnt16 term_cnt", ACC_W'(term_cnt), ACC_W'(16));
        check("cnt16 ovf", ACC_W'(ovf), ACC_W'(1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
